uart_rx: RTL and testbench

//  Oversampling UART receiver, the receive-side peer of the uart_tx path. Recovers
//  8N1 frames (8E1 with parity option) from the asynchronous RxD line and presents

---
 rtl/uart_pkg.sv | 11 +
 rtl/uart_baud_tick.sv | 16 +
 rtl/uart_rx.sv | 110 +++++++++++
 tb/tb_uart_rx.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, baud/oversample defaults and tick divider helper
package uart_pkg;
    localparam int DEF_CLK_FREQ   = 100_000_000;
    localparam int DEF_BAUD       = 9600;
    localparam int DEF_OVERSAMPLE = 16;
    localparam int DEF_DATA_W     = 8;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} rx_state_t;
    function automatic int tick_div(input int clk_freq, input int baud, input int os);
        return clk_freq / (baud * os);
    endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divider, one-cycle tick every DIV clocks, sync restart
module uart_baud_tick #(
    parameter int DIV = 651
) (
    input  logic clk_i,
    input  logic arst_i,
    input  logic restart,
    output logic tick
);
    localparam int W = DIV > 1 ? $clog2(DIV) : 1;
    logic [W-1:0] cnt;
    assign tick = cnt == W'(DIV - 1);
    always_ff @(posedge clk_i or posedge arst_i)
        if (arst_i) cnt <= '0;
        else cnt <= (restart || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling 8N1 UART receiver with one-cycle valid/error pulses.
// Define UART_RX_PARITY_EN for an even parity bit (8E1) and parity_err_o.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = DEF_CLK_FREQ,
    parameter int BAUD       = DEF_BAUD,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int DATA_W     = DEF_DATA_W
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              RxD_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              frame_err_o,
    output logic              parity_err_o
);
    localparam int TICK_DIV = tick_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = DATA_W > 1 ? $clog2(DATA_W) : 1;
    rx_state_t state, state_n;
    logic [1:0] sync;
    logic rx_s, tick, restart, s_half, s_last, b_last;
    logic [SW-1:0] s_cnt, s_cnt_n;
    logic [BW-1:0] b_cnt, b_cnt_n;
    logic [DATA_W-1:0] shift, shift_n, data_n;
    logic par_bad, par_bad_n, valid_n, ferr_n, perr_n;
    assign rx_s   = sync[1];
    assign s_half = s_cnt == SW'(OVERSAMPLE / 2 - 1);
    assign s_last = s_cnt == SW'(OVERSAMPLE - 1);
    assign b_last = b_cnt == BW'(DATA_W - 1);
    uart_baud_tick #(.DIV(TICK_DIV)) u_tick (
        .clk_i(clk_i), .arst_i(arst_i), .restart(restart), .tick(tick)
    );
    always_ff @(posedge clk_i or posedge arst_i)
        if (arst_i) begin
            sync         <= 2'b11;
            state        <= IDLE;
            s_cnt        <= '0;
            b_cnt        <= '0;
            shift        <= '0;
            par_bad      <= 1'b0;
            data_o       <= '0;
            valid_o      <= 1'b0;
            frame_err_o  <= 1'b0;
            parity_err_o <= 1'b0;
        end else begin
            sync         <= {sync[0], RxD_i};
            state        <= state_n;
            s_cnt        <= s_cnt_n;
            b_cnt        <= b_cnt_n;
            shift        <= shift_n;
            par_bad      <= par_bad_n;
            data_o       <= data_n;
            valid_o      <= valid_n;
            frame_err_o  <= ferr_n;
            parity_err_o <= perr_n;
        end
    always_comb begin
        state_n   = state;
        s_cnt_n   = s_cnt;
        b_cnt_n   = b_cnt;
        shift_n   = shift;
        par_bad_n = par_bad;
        data_n    = data_o;
        valid_n   = 1'b0;
        ferr_n    = 1'b0;
        perr_n    = 1'b0;
        restart   = 1'b0;
        if (tick && state != IDLE && state != BREAK)
            s_cnt_n = (s_last || (state == START && s_half)) ? '0 : s_cnt + 1'b1;
        case (state)
            IDLE: begin
                restart = !rx_s;
                state_n = rx_s ? IDLE : START;
                s_cnt_n = '0;
            end
            START: if (tick && s_half) begin
                state_n = rx_s ? IDLE : DATA;
                b_cnt_n = '0;
            end
            DATA: if (tick && s_last) begin
                shift_n   = {rx_s, shift[DATA_W-1:1]};
                b_cnt_n   = b_cnt + 1'b1;
                par_bad_n = 1'b0;
`ifdef UART_RX_PARITY_EN
                state_n   = b_last ? PARITY : DATA;
`else
                state_n   = b_last ? STOP : DATA;
`endif
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (tick && s_last) begin
                par_bad_n = rx_s ^ (^shift);
                state_n   = STOP;
            end
`endif
            STOP: if (tick && s_last) begin
                state_n = rx_s ? IDLE : BREAK;
                valid_n = rx_s && !par_bad;
                perr_n  = rx_s && par_bad;
                ferr_n  = !rx_s;
                data_n  = (rx_s && !par_bad) ? shift : data_o;
            end
            BREAK: state_n = rx_s ? IDLE : BREAK;
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames against uart_rx at a scaled-down bit period (160 clk).
// Parity scenario runs only when UART_RX_PARITY_EN is defined.
module tb_uart_rx;
    import uart_pkg::*;
    localparam int BIT = 160;
    logic clk = 1'b0, arst = 1'b1, rxd = 1'b1;
    logic [7:0] data;
    logic valid, ferr, perr;
    int n_cmp = 0, n_bad = 0;
    int n_valid = 0, n_ferr = 0, n_perr = 0, n_multi = 0;
    logic [7:0] rxq[$];
    int v0, f0, p0, m0;

    uart_rx #(.CLK_FREQ(1_600_000), .BAUD(10_000), .OVERSAMPLE(16), .DATA_W(8)) dut (
        .clk_i(clk), .arst_i(arst), .RxD_i(rxd), .data_o(data),
        .valid_o(valid), .frame_err_o(ferr), .parity_err_o(perr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid) begin n_valid++; rxq.push_back(data); end
        if (ferr) n_ferr++;
        if (perr) n_perr++;
        if (int'(valid) + int'(ferr) + int'(perr) > 1) n_multi++;
    end

    task automatic drive_bit(input logic b, input int clks);
        rxd = b;
        repeat (clks) @(posedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic par, input logic stop);
        drive_bit(1'b0, BIT);
        for (int i = 0; i < 8; i++) drive_bit(b[i], BIT);
`ifdef UART_RX_PARITY_EN
        drive_bit(par, BIT);
`endif
        drive_bit(stop, BIT);
    endtask

    task automatic snap;
        v0 = n_valid; f0 = n_ferr; p0 = n_perr; m0 = n_multi;
        rxq.delete();
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", data); end
        n_cmp++; if ({valid, ferr, perr} !== 3'b000) begin n_bad++; $display("FAIL reset_pulses: got %b want 000", {valid, ferr, perr}); end
        arst = 1'b0;
        repeat (2 * BIT) @(posedge clk);
        n_cmp++; if (n_valid + n_ferr + n_perr !== 0) begin n_bad++; $display("FAIL idle_no_pulse: got %0d want 0", n_valid + n_ferr + n_perr); end
    endtask

    task automatic test_single;
        snap();
        send(8'hA5, ^8'hA5, 1'b1);
        repeat (BIT) @(posedge clk);
        n_cmp++; if (n_valid - v0 !== 1) begin n_bad++; $display("FAIL a5_valid_count: got %0d want 1", n_valid - v0); end
        n_cmp++; if (data !== 8'hA5) begin n_bad++; $display("FAIL a5_data: got %h want a5", data); end
        n_cmp++; if (n_ferr - f0 + n_perr - p0 !== 0) begin n_bad++; $display("FAIL a5_err: got %0d want 0", n_ferr - f0 + n_perr - p0); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp [3];
        exp = '{8'h00, 8'hFF, 8'h3C};
        snap();
        for (int i = 0; i < 3; i++) send(exp[i], ^exp[i], 1'b1);
        repeat (BIT) @(posedge clk);
        n_cmp++; if (n_valid - v0 !== 3) begin n_bad++; $display("FAIL b2b_count: got %0d want 3", n_valid - v0); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (rxq.size() <= i || rxq[i] !== exp[i]) begin
                n_bad++;
                $display("FAIL b2b_byte%0d: got %h want %h", i, rxq.size() > i ? rxq[i] : 8'hxx, exp[i]);
            end
        end
        n_cmp++; if (n_multi - m0 + n_ferr - f0 !== 0) begin n_bad++; $display("FAIL b2b_err: got %0d want 0", n_multi - m0 + n_ferr - f0); end
    endtask

    task automatic test_glitch;
        snap();
        drive_bit(1'b0, 40);
        drive_bit(1'b1, 2 * BIT);
        n_cmp++; if (n_valid - v0 + n_ferr - f0 + n_perr - p0 !== 0) begin n_bad++; $display("FAIL glitch_pulse: got %0d want 0", n_valid - v0 + n_ferr - f0 + n_perr - p0); end
        n_cmp++; if (dut.state !== IDLE) begin n_bad++; $display("FAIL glitch_state: got %0d want %0d", dut.state, IDLE); end
        n_cmp++; if (data !== 8'h3C) begin n_bad++; $display("FAIL glitch_data: got %h want 3c", data); end
    endtask

    task automatic test_frame_err;
        snap();
        send(8'h55, ^8'h55, 1'b0);
        drive_bit(1'b0, 5 * BIT);
        drive_bit(1'b1, 2 * BIT);
        n_cmp++; if (n_ferr - f0 !== 1) begin n_bad++; $display("FAIL ferr_count: got %0d want 1", n_ferr - f0); end
        n_cmp++; if (n_valid - v0 !== 0) begin n_bad++; $display("FAIL ferr_valid: got %0d want 0", n_valid - v0); end
        n_cmp++; if (data !== 8'h3C) begin n_bad++; $display("FAIL ferr_data_hold: got %h want 3c", data); end
        snap();
        send(8'h12, ^8'h12, 1'b1);
        repeat (BIT) @(posedge clk);
        n_cmp++; if (n_valid - v0 !== 1 || data !== 8'h12) begin n_bad++; $display("FAIL after_ferr_12: got %0d/%h want 1/12", n_valid - v0, data); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] b;
        b = 8'hC3;
        snap();
        drive_bit(1'b0, BIT);
        for (int i = 0; i < 4; i++) drive_bit(b[i], BIT);
        drive_bit(b[4], BIT / 2);
        arst = 1'b1;
        #1;
        n_cmp++; if (data !== 8'h00 || {valid, ferr, perr} !== 3'b000) begin n_bad++; $display("FAIL midreset_out: got %h/%b want 00/000", data, {valid, ferr, perr}); end
        drive_bit(b[4], BIT / 2);
        for (int i = 5; i < 8; i++) drive_bit(b[i], BIT);
        drive_bit(1'b1, BIT);
        arst = 1'b0;
        drive_bit(1'b1, 2 * BIT);
        n_cmp++; if (n_valid - v0 + n_ferr - f0 + n_perr - p0 !== 0) begin n_bad++; $display("FAIL midreset_pulse: got %0d want 0", n_valid - v0 + n_ferr - f0 + n_perr - p0); end
        n_cmp++; if (data !== 8'h00) begin n_bad++; $display("FAIL midreset_data: got %h want 00", data); end
        snap();
        send(8'h81, ^8'h81, 1'b1);
        repeat (BIT) @(posedge clk);
        n_cmp++; if (n_valid - v0 !== 1 || data !== 8'h81) begin n_bad++; $display("FAIL after_reset_81: got %0d/%h want 1/81", n_valid - v0, data); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        snap();
        send(8'h07, 1'b0, 1'b1);
        repeat (BIT) @(posedge clk);
        n_cmp++; if (n_perr - p0 !== 1 || n_valid - v0 !== 0) begin n_bad++; $display("FAIL par_bad: got perr %0d valid %0d want 1 0", n_perr - p0, n_valid - v0); end
        n_cmp++; if (data !== 8'h81) begin n_bad++; $display("FAIL par_bad_data: got %h want 81", data); end
        snap();
        send(8'h07, 1'b1, 1'b1);
        repeat (BIT) @(posedge clk);
        n_cmp++; if (n_valid - v0 !== 1 || n_perr - p0 !== 0 || data !== 8'h07) begin n_bad++; $display("FAIL par_good: got %0d/%0d/%h want 1/0/07", n_valid - v0, n_perr - p0, data); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_mid();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        n_cmp++; if (n_multi !== 0) begin n_bad++; $display("FAIL pulse_exclusive: got %0d want 0", n_multi); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
